alu_display_driver: RTL



---
 rtl/alu_display_driver.sv | 163 ++++++++++++++++
 1 files changed

// File: rtl/alu_display_driver.sv
// alu_display_driver
// Latches a sign-magnitude ALU result with its flags on a load strobe and
// scans it onto a 4-digit common-anode seven-segment display. Divide-by-zero
// shows "Err"; negative non-zero values get a leading minus in digit 2.
module alu_display_driver #(
    parameter int REFRESH_DIV = 50000,
    parameter int DIV_W       = 16
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       load,
    input  logic [4:0] result,
    input  logic       zero,
    input  logic       divbyzero,
    output logic [6:0] seg,
    output logic [3:0] an,
    output logic       valid
);

    // Character codes fed to the segment encoder
    localparam logic [3:0] CH_ONE   = 4'd1;
    localparam logic [3:0] CH_MINUS = 4'd10;
    localparam logic [3:0] CH_E     = 4'd11;
    localparam logic [3:0] CH_R     = 4'd12;
    localparam logic [3:0] CH_BLANK = 4'd15;

    localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(REFRESH_DIV - 1);

    // Active-low segment pattern (g..a) for a character code
    function automatic logic [6:0] seg_encode(input logic [3:0] ch);
        logic [6:0] pat;
        case (ch)
            4'd0:    pat = 7'b1000000;
            4'd1:    pat = 7'b1111001;
            4'd2:    pat = 7'b0100100;
            4'd3:    pat = 7'b0110000;
            4'd4:    pat = 7'b0011001;
            4'd5:    pat = 7'b0010010;
            4'd6:    pat = 7'b0000010;
            4'd7:    pat = 7'b1111000;
            4'd8:    pat = 7'b0000000;
            4'd9:    pat = 7'b0010000;
            4'd10:   pat = 7'b0111111;
            4'd11:   pat = 7'b0000110;
            4'd12:   pat = 7'b0101111;
            default: pat = 7'b1111111;
        endcase
        return pat;
    endfunction

    logic [4:0]       held_result_r;
    logic             held_zero_r;
    logic             held_dbz_r;
    logic             valid_r;
    logic [DIV_W-1:0] div_cnt_r;
    logic [1:0]       digit_idx_r;
    logic [6:0]       seg_r;
    logic [3:0]       an_r;

    logic [3:0]       mag_s;
    logic             neg_s;
    logic [3:0]       char_s;
    logic [6:0]       seg_nxt_s;
    logic [3:0]       an_nxt_s;

    // Capture the datapath result and flags on load; last load wins
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            held_result_r <= 5'd0;
            held_zero_r   <= 1'b0;
            held_dbz_r    <= 1'b0;
            valid_r       <= 1'b0;
        end else if (load) begin
            held_result_r <= result;
            held_zero_r   <= zero;
            held_dbz_r    <= divbyzero;
            valid_r       <= 1'b1;
        end
    end

    // Free-running refresh divider and digit scan, independent of load
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt_r   <= '0;
            digit_idx_r <= 2'd0;
        end else if (div_cnt_r == DIV_LAST) begin
            div_cnt_r   <= '0;
            digit_idx_r <= digit_idx_r + 2'd1;
        end else begin
            div_cnt_r   <= div_cnt_r + {{(DIV_W-1){1'b0}}, 1'b1};
        end
    end

    // Select the character for the digit being scanned and build the drive
    always_comb begin
        mag_s     = held_result_r[3:0];
        neg_s     = held_result_r[4];
        char_s    = CH_BLANK;
        seg_nxt_s = 7'b1111111;
        an_nxt_s  = 4'b1111;

        case (digit_idx_r)
            2'd0: begin
                if (held_dbz_r) begin
                    char_s = CH_R;
                end else if (held_zero_r && (mag_s == 4'd0)) begin
                    // Flag agrees with the magnitude; M stays authoritative otherwise
                    char_s = 4'd0;
                end else if (mag_s >= 4'd10) begin
                    char_s = mag_s - 4'd10;
                end else begin
                    char_s = mag_s;
                end
            end
            2'd1: begin
                if (held_dbz_r) begin
                    char_s = CH_R;
                end else if (mag_s >= 4'd10) begin
                    char_s = CH_ONE;
                end else begin
                    char_s = CH_BLANK;
                end
            end
            2'd2: begin
                if (held_dbz_r) begin
                    char_s = CH_E;
                end else if (neg_s && (mag_s != 4'd0)) begin
                    // Negative zero is shown without a minus
                    char_s = CH_MINUS;
                end else begin
                    char_s = CH_BLANK;
                end
            end
            default: begin
                char_s = CH_BLANK;
            end
        endcase

        if (valid_r) begin
            seg_nxt_s = seg_encode(char_s);
            an_nxt_s  = ~(4'b0001 << digit_idx_r);
        end else begin
            seg_nxt_s = 7'b1111111;
            an_nxt_s  = 4'b1111;
        end
    end

    // Register the display drive for glitch-free outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg_r <= 7'b1111111;
            an_r  <= 4'b1111;
        end else begin
            seg_r <= seg_nxt_s;
            an_r  <= an_nxt_s;
        end
    end

    assign seg   = seg_r;
    assign an    = an_r;
    assign valid = valid_r;

endmodule
